// File: rtl/hist_pkg.sv
// Shared definitions for the histogram block: default geometry and the
// sequencer state encoding. The histogram writer FSM imports this as well.
package hist_pkg;

  localparam int BIN_W_DEF = 10;  // log2 bins per pixel
  localparam int PIX_W_DEF = 2;   // log2 pixels per histogram RAM
  localparam int CNT_W_DEF = 8;   // width of one bin count

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/peak_tracker.sv
// Running maximum of a stream of bin counts. Only a strictly larger count
// replaces the held value, so ties keep the lowest bin. Counts are unsigned.
module peak_tracker
  import hist_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             init,
  input  logic             valid,
  input  logic [CNT_W-1:0] data,
  input  logic [BIN_W-1:0] bin,
  output logic [CNT_W-1:0] max_cnt,
  output logic [BIN_W-1:0] max_bin
);

  logic [CNT_W-1:0] r_max_cnt;
  logic [BIN_W-1:0] r_max_bin;

  // Clear on reset or pixel start, otherwise capture strictly larger counts
  always_ff @(posedge clk) begin
    if (!res) begin
      r_max_cnt <= '0;
      r_max_bin <= '0;
    end else if (init) begin
      r_max_cnt <= '0;
      r_max_bin <= '0;
    end else if (valid && (data > r_max_cnt)) begin
      r_max_cnt <= data;
      r_max_bin <= bin;
    end
  end

  assign max_cnt = r_max_cnt;
  assign max_bin = r_max_bin;

endmodule

// File: rtl/hist_readout.sv
// Histogram readout sequencer. Sweeps every bin of every pixel through the
// histogram RAM, optionally clearing each bin after it is read, and emits the
// peak bin/count of each pixel on a result stream.
//
// Result stream handshake: out_valid rises when a pixel's peak is known and
// stays high with out_pix/out_bin/out_cnt frozen until a cycle in which
// out_ready is also high; that cycle is the transfer. out_ready may be held
// high permanently, in which case each result is presented for one cycle.
module hist_readout
  import hist_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic               clear_en,
  output logic [PIX_W+BIN_W-1:0] raddr,
  output logic               ren,
  input  logic [CNT_W-1:0]   rdata,
  output logic [PIX_W+BIN_W-1:0] waddr,
  output logic               wen,
  output logic [CNT_W-1:0]   wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic [BIN_W-1:0]   out_bin,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state
);

  localparam int AW = PIX_W + BIN_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PIX_W-1:0] r_pix;
  logic [PIX_W-1:0] w_pix_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [BIN_W-1:0] w_bin_nxt;
  logic             r_clr;       // clear mode latched at start
  logic             w_clr_nxt;
  logic             r_rd_vld;    // a read was issued last cycle, rdata is live
  logic [AW-1:0]    r_prev_addr; // address of that read, reused for the clear
  logic             w_ren;
  logic             w_init;
  logic             w_last_bin;
  logic             w_last_pix;
  logic [AW-1:0]    w_raddr;
  logic [CNT_W-1:0] w_max_cnt;
  logic [BIN_W-1:0] w_max_bin;
  logic [BIN_W-1:0] w_rd_bin;

  assign w_last_bin = (r_bin == {BIN_W{1'b1}});
  assign w_last_pix = (r_pix == {PIX_W{1'b1}});
  assign w_raddr    = w_ren ? {r_pix, r_bin} : '0;
  assign w_rd_bin   = r_prev_addr[BIN_W-1:0];

  // Next-state, counter and read-issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix;
    w_bin_nxt   = r_bin;
    w_clr_nxt   = r_clr;
    w_ren       = 1'b0;
    w_init      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_READ;
          w_pix_nxt   = '0;
          w_bin_nxt   = '0;
          w_clr_nxt   = clear_en;
        end
      end
      ST_READ: begin
        w_ren     = 1'b1;
        // first read of a pixel: restart the peak search
        w_init    = (r_bin == '0);
        w_bin_nxt = r_bin + 1'b1;
        if (w_last_bin) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // last rdata of the pixel is consumed here
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (w_last_pix) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_READ;
            w_pix_nxt   = r_pix + 1'b1;
            w_bin_nxt   = '0;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and the one-cycle read pipeline
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state     <= ST_IDLE;
      r_pix       <= '0;
      r_bin       <= '0;
      r_clr       <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_prev_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix       <= w_pix_nxt;
      r_bin       <= w_bin_nxt;
      r_clr       <= w_clr_nxt;
      r_rd_vld    <= w_ren;
      r_prev_addr <= w_raddr;
    end
  end

  peak_tracker #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_peak (
    .clk     (clk),
    .res     (res),
    .init    (w_init),
    .valid   (r_rd_vld),
    .data    (rdata),
    .bin     (w_rd_bin),
    .max_cnt (w_max_cnt),
    .max_bin (w_max_bin)
  );

  assign ren       = w_ren;
  assign raddr     = w_raddr;
  // clear each bin in the cycle its data comes back
  assign wen       = r_rd_vld && r_clr;
  assign waddr     = wen ? r_prev_addr : '0;
  assign wdata     = '0;
  assign out_valid = (r_state == ST_EMIT);
  assign out_pix   = out_valid ? r_pix     : '0;
  assign out_bin   = out_valid ? w_max_bin : '0;
  assign out_cnt   = out_valid ? w_max_cnt : '0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: doc/hist_readout.md
HIST_READOUT -- requirements
Module: hist_readout

Interface
REQ-001 SHALL have parameter BIN_W, default 10, meaning log2 of histogram bins per pixel.
REQ-002 SHALL have parameter PIX_W, default 2, meaning log2 of pixels per histogram RAM.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of one histogram bin count.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port res, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1, meaning pulse requesting one readout sweep of all pixels.
REQ-007 SHALL have port clear_en, input, 1, meaning zero each bin after reading it; sampled at start.
REQ-008 SHALL have port raddr, output, PIX_W+BIN_W, meaning RAM read address, {pixel, bin}.
REQ-009 SHALL have port ren, output, 1, meaning RAM read enable, active-high.
REQ-010 SHALL have port rdata, input, CNT_W, meaning RAM read data, valid one cycle after ren.
REQ-011 SHALL have port waddr, output, PIX_W+BIN_W, meaning RAM clear-write address.
REQ-012 SHALL have port wen, output, 1, meaning RAM write enable, active-high.
REQ-013 SHALL have port wdata, output, CNT_W, meaning RAM write data, always 0.
REQ-014 SHALL have ports out_valid output 1, out_ready input 1, out_pix output PIX_W, out_bin output BIN_W, out_cnt output CNT_W, meaning per-pixel peak result stream.
REQ-015 SHALL have ports busy, output, 1 (sweep active) and done, output, 1 (one-cycle end-of-sweep pulse).

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, EMIT, DONE.
REQ-017 IDLE: start=1 SHALL go to READ next cycle with pixel=0, bin=0, clear mode latched from clear_en; start in any other state SHALL be ignored.
REQ-018 READ: SHALL assert ren with raddr={pixel,bin}, increment bin each cycle; after bin=2^BIN_W-1 is issued SHALL go to DRAIN.
REQ-019 DRAIN: SHALL last one cycle, consuming the final rdata, then go to EMIT.
REQ-020 Each cycle following a ren cycle SHALL compare rdata against running max; strictly greater SHALL replace max and its bin (ties keep lowest bin); max/bin SHALL initialise to 0/0 per pixel.
REQ-021 In clear mode, the cycle rdata is consumed SHALL assert wen, waddr equal to the previous raddr, wdata=0; otherwise wen=0.
REQ-022 EMIT: SHALL hold out_valid=1 with stable out_pix/out_bin/out_cnt until out_valid&&out_ready; no RAM access during EMIT.
REQ-023 On handshake: pixel<2^PIX_W-1 SHALL return to READ with pixel+1, bin=0; last pixel SHALL go to DONE.
REQ-024 DONE: SHALL pulse done=1 for exactly one cycle, then IDLE.
REQ-025 busy SHALL be 1 in READ, DRAIN, EMIT, DONE; 0 in IDLE.
REQ-026 Per-pixel latency SHALL be 2^BIN_W+1 cycles from first ren to out_valid, with no bubbles when out_ready is held high.
REQ-027 All-zero pixel SHALL report out_bin=0, out_cnt=0; saturated count (all ones) SHALL be compared unsigned without overflow.

Reset
REQ-028 res=0 at a clock edge SHALL force IDLE and zero raddr, ren, waddr, wen, out_valid, out_pix, out_bin, out_cnt, busy, done, max registers.
REQ-029 Reset mid-sweep SHALL abandon the sweep without done pulse or further RAM writes; bins already cleared stay cleared.

Structure
REQ-030 BIN_W/PIX_W/CNT_W defaults and the state enum SHALL live in shared package hist_pkg, also used by the histogram writer FSM.
REQ-031 The compare/max logic SHALL be one sub-module, peak_tracker (inputs: init, valid, data, bin; outputs: max_cnt, max_bin).

Verification (BIN_W=3, PIX_W=1, CNT_W=8, 1-cycle RAM model)
REQ-032 Pixel0 bins {1,5,2,9,9,0,3,4}, pixel1 all 0, out_ready=1, start pulse -> (pix0, bin3, cnt9) then (pix1, bin0, cnt0), done pulse once, busy falls after done.
REQ-033 clear_en=1 sweep -> 16 wen cycles at waddr 0..15 each one cycle after matching raddr; second sweep reports all cnt=0.
REQ-034 out_ready=0 for 5 cycles at first EMIT -> out_valid and fields stable 5 cycles, no ren, pixel1 read starts cycle after handshake.
REQ-035 start re-pulsed during READ -> ignored; exactly 2 results and 1 done.
REQ-036 res=0 during pixel1 READ -> next cycle IDLE, all outputs 0, no done; fresh start then completes normally.
REQ-037 Pixel0 bin7=255, others 254 -> (pix0, bin7, cnt255).
